// File: rtl/gold_code_correlator_pkg.sv
// Shared definitions for the Gold-code correlator: code geometry, LFSR masks,
// acquisition thresholds, FSM state encoding and small replica helpers.
package gold_code_correlator_pkg;

   localparam int N        = 5;
   localparam int L        = (1 << N) - 1;
   localparam int THRESH   = 23;
   localparam int CONFIRM  = 2;
   localparam int MISS_MAX = 3;
   localparam int CNT_W    = 4;

   localparam logic [N-1:0] G1_MASK = 5'b10100;
   localparam logic [N-1:0] G2_MASK = 5'b11110;
   localparam logic [N-1:0] SEED    = 5'b11111;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCK   = 2'd2
   } state_t;

   // One Fibonacci step: shift left, feedback parity enters at bit 0.
   function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] g, input logic [N-1:0] mask);
      return {g[N-2:0], ^(g & mask)};
   endfunction

   // Code phase counts slips modulo the code period.
   function automatic logic [N-1:0] phase_inc(input logic [N-1:0] p);
      return (p == N'(L - 1)) ? '0 : p + N'(1);
   endfunction

endpackage

// File: rtl/gold_lfsr_pair.sv
// Local Gold replica: two N-bit LFSRs stepped together; the chip is the XOR of
// their MSBs. Same recurrence as the upstream generator.
module gold_lfsr_pair
   import gold_code_correlator_pkg::*;
(
   input  logic clk,
   input  logic load,
   input  logic advance,
   output logic chip
);

   logic [N-1:0] g1;
   logic [N-1:0] g2;

   // Reload the seed on request, otherwise step both registers on advance.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (load) begin
         g1 <= SEED;
         g2 <= SEED;
      end else if (advance) begin
         g1 <= lfsr_step(g1, G1_MASK);
         g2 <= lfsr_step(g2, G2_MASK);
      end
   end

   assign chip = g1[N-1] ^ g2[N-1];

endmodule

// File: rtl/gold_code_correlator.sv
// Gold-code correlator: integrates chip agreement against a local replica over
// each code period, slips the replica one chip per failed epoch, and walks a
// SEARCH / VERIFY / LOCK acquisition FSM on every epoch result.
module gold_code_correlator
   import gold_code_correlator_pkg::*;
(
   input  logic         clk,
   input  logic         rstn,
   input  logic         chip_in,
   input  logic         chip_valid,
   output logic [N+1:0] corr,
   output logic         corr_valid,
   output logic [N-1:0] code_phase,
   output logic [1:0]   state,
   output logic         lock
);

   state_t           state_q;
   logic [N-1:0]     epoch;
   logic [N-1:0]     agree;
   logic [N-1:0]     agree_final;
   logic [N+1:0]     corr_calc;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;
   logic             slip_armed;
   logic             advance;
   logic             rep_chip;
   logic             epoch_end;
   logic             hit;

   gold_lfsr_pair u_replica (
      .clk     (clk),
      .load    (!rstn),
      .advance (advance),
      .chip    (rep_chip)
   );

   // Per-chip accumulation and epoch-end correlation, all combinational.
   always_comb begin
      // NOTE: every output of this block is assigned on every pass, so no latch.
      advance     = chip_valid && !slip_armed;
      agree_final = agree + N'(advance && (chip_in == rep_chip));
      epoch_end   = advance && (epoch == N'(L - 1));
      corr_calc   = {1'b0, agree_final, 1'b0} - (N+2)'(L);
      hit         = $signed(corr_calc) >= $signed((N+2)'(THRESH));
   end

   // Accumulator, slip control and acquisition FSM with registered outputs.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge only; all state clears here.
      if (!rstn) begin
         epoch      <= '0;
         agree      <= '0;
         corr       <= '0;
         corr_valid <= 1'b0;
         code_phase <= '0;
         state_q    <= ST_SEARCH;
         lock       <= 1'b0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         slip_armed <= 1'b0;
      end else begin
         corr_valid <= 1'b0;
         if (chip_valid && slip_armed) begin
            // Discarded chip: replica, epoch and agree all hold.
            slip_armed <= 1'b0;
         end else if (epoch_end) begin
            epoch      <= '0;
            agree      <= '0;
            corr       <= corr_calc;
            corr_valid <= 1'b1;
            case (state_q)
               ST_SEARCH: begin
                  if (hit) begin
                     hit_cnt  <= CNT_W'(1);
                     miss_cnt <= '0;
                     if (CONFIRM == 1) begin
                        state_q <= ST_LOCK;
                        lock    <= 1'b1;
                     end else begin
                        state_q <= ST_VERIFY;
                     end
                  end else begin
                     slip_armed <= 1'b1;
                     code_phase <= phase_inc(code_phase);
                  end
               end
               ST_VERIFY: begin
                  if (hit) begin
                     hit_cnt <= hit_cnt + CNT_W'(1);
                     if (hit_cnt + CNT_W'(1) == CNT_W'(CONFIRM)) begin
                        state_q  <= ST_LOCK;
                        lock     <= 1'b1;
                        miss_cnt <= '0;
                     end
                  end else begin
                     state_q    <= ST_SEARCH;
                     hit_cnt    <= '0;
                     slip_armed <= 1'b1;
                     code_phase <= phase_inc(code_phase);
                  end
               end
               ST_LOCK: begin
                  if (hit) begin
                     miss_cnt <= '0;
                  end else if (miss_cnt + CNT_W'(1) == CNT_W'(MISS_MAX)) begin
                     state_q    <= ST_SEARCH;
                     lock       <= 1'b0;
                     miss_cnt   <= '0;
                     hit_cnt    <= '0;
                     slip_armed <= 1'b1;
                     code_phase <= phase_inc(code_phase);
                  end else begin
                     miss_cnt <= miss_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state_q <= ST_SEARCH;
                  lock    <= 1'b0;
               end
            endcase
         end else if (advance) begin
            epoch <= epoch + N'(1);
            agree <= agree_final;
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_gold_code_correlator.sv
// Self-checking bench for gold_code_correlator: a per-epoch behavioural model
// pushes expected results into a scoreboard, a monitor pops on corr_valid.
module tb_gold_code_correlator;

   localparam int TB_L       = 31;
   localparam int TB_THRESH  = 23;
   localparam int TB_CONFIRM = 2;
   localparam int TB_MISSMAX = 3;

   typedef struct {
      int corr;
      int phase;
      int st;
      int lk;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       chip_in = 1'b0;
   logic       chip_valid = 1'b0;
   logic [6:0] corr;
   logic       corr_valid;
   logic [4:0] code_phase;
   logic [1:0] state;
   logic       lock;

   int errors = 0;
   int checks = 0;

   bit   code [TB_L];
   exp_t sb [$];

   // Reference model state, expressed in code positions and plain counts.
   int m_pos, m_agree, m_phase, m_state, m_hits, m_misses, m_epochs;
   bit m_slip;
   int t_in;
   int lag;
   int mode;   // 0 code, 1 inverted code, 2 all zeros

   gold_code_correlator dut (
      .clk        (clk),
      .rstn       (rstn),
      .chip_in    (chip_in),
      .chip_valid (chip_valid),
      .corr       (corr),
      .corr_valid (corr_valid),
      .code_phase (code_phase),
      .state      (state),
      .lock       (lock)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One code period of the Gold sequence from the generator recurrence.
   task automatic build_code();
      logic [4:0] g1, g2;
      g1 = 5'b11111;
      g2 = 5'b11111;
      for (int i = 0; i < TB_L; i++) begin
         code[i] = g1[4] ^ g2[4];
         g1 = {g1[3:0], ^(g1 & 5'b10100)};
         g2 = {g2[3:0], ^(g2 & 5'b11110)};
      end
   endtask

   function automatic bit src_chip(input int t);
      int idx;
      idx = ((t - lag) % TB_L + TB_L) % TB_L;
      case (mode)
         1:       return ~code[idx];
         2:       return 1'b0;
         default: return code[idx];
      endcase
   endfunction

   task automatic model_reset();
      m_pos = 0; m_agree = 0; m_phase = 0; m_state = 0;
      m_hits = 0; m_misses = 0; m_slip = 0; t_in = 0;
   endtask

   task automatic model_slip();
      m_slip  = 1'b1;
      m_phase = (m_phase + 1) % TB_L;
   endtask

   task automatic model_chip(input bit c);
      int  cv;
      bit  h;
      if (m_slip) begin
         m_slip = 1'b0;
         return;
      end
      if (c == code[m_pos]) m_agree++;
      m_pos++;
      if (m_pos == TB_L) begin
         cv = 2 * m_agree - TB_L;
         h  = (cv >= TB_THRESH);
         case (m_state)
            0: if (h) begin
                  m_hits = 1; m_misses = 0;
                  m_state = (TB_CONFIRM == 1) ? 2 : 1;
               end else model_slip();
            1: if (h) begin
                  m_hits++;
                  if (m_hits == TB_CONFIRM) begin m_state = 2; m_misses = 0; end
               end else begin
                  m_state = 0; m_hits = 0; model_slip();
               end
            default: if (h) m_misses = 0;
               else begin
                  m_misses++;
                  if (m_misses == TB_MISSMAX) begin
                     m_state = 0; m_misses = 0; m_hits = 0; model_slip();
                  end
               end
         endcase
         sb.push_back('{cv, m_phase, m_state, int'(m_state == 2)});
         m_pos = 0;
         m_agree = 0;
         m_epochs++;
      end
   endtask

   // Drive one clock's worth of input just after the rising edge.
   task automatic cycle(input bit v);
      @(posedge clk);
      #1;
      chip_valid = v;
      if (v) begin
         chip_in = src_chip(t_in);
         t_in++;
         model_chip(chip_in);
      end else begin
         chip_in = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      model_reset();
      repeat (n) begin
         @(posedge clk);
         #1;
         chip_valid = ~chip_valid;
         chip_in    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("rst_corr", int'(corr), 0);
      check("rst_corr_valid", int'(corr_valid), 0);
      check("rst_code_phase", int'(code_phase), 0);
      check("rst_state", int'(state), 0);
      check("rst_lock", int'(lock), 0);
      @(posedge clk);
      #1;
      chip_valid = 1'b0;
      rstn = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && sb.size() != 0; i++) cycle(1'b0);
      check("scoreboard_drained", sb.size(), 0);
   endtask

   task automatic run_epochs(input int n, input int duty);
      int target;
      int budget;
      target = m_epochs + n;
      budget = n * 32 * 200 / duty + 200;
      while (m_epochs < target && budget > 0) begin
         cycle($urandom_range(0, 99) < duty);
         budget--;
      end
      check("epoch_budget_left", int'(m_epochs >= target), 1);
      drain();
   endtask

   // Monitor: every corr_valid pulse must match the oldest expected epoch.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (corr_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("spurious_corr_valid", int'(corr_valid), 0);
            end else begin
               e = sb.pop_front();
               check("corr", int'($signed(corr)), e.corr);
               check("code_phase", int'(code_phase), e.phase);
               check("state", int'(state), e.st);
               check("lock", int'(lock), e.lk);
            end
         end
      end
   end

   initial begin
      int pre;
      build_code();
      m_epochs = 0;
      lag = 0;
      mode = 0;
      model_reset();

      // Reset with chip_valid toggling.
      do_reset(5);

      // Aligned stream, no gaps.
      run_epochs(2, 100);
      check("aligned_lock", int'(lock), 1);
      check("aligned_phase", int'(code_phase), 0);
      run_epochs(2, 100);

      // Locked, then all-zero chips: lock drops on the third miss.
      mode = 2;
      run_epochs(3, 100);
      check("drop_lock", int'(lock), 0);
      check("drop_state", int'(state), 0);
      check("drop_phase", int'(code_phase), 1);
      mode = 0;
      run_epochs(2, 100);

      // Input lagging the aligned code by 7 chips.
      do_reset(2);
      lag = 7;
      run_epochs(9, 100);
      check("lag7_lock", int'(lock), 1);
      check("lag7_phase", int'(code_phase), 7);

      // Inverted stream never hits; phase wraps after 31 slips.
      do_reset(2);
      lag = 0;
      mode = 1;
      run_epochs(31, 100);
      check("inv_lock", int'(lock), 0);
      check("inv_phase_wrap", int'(code_phase), 0);

      // Random gaps, random lag, reset pulse mid-epoch, then reacquire.
      do_reset(2);
      mode = 0;
      lag = $urandom_range(0, 30);
      run_epochs(3, 40);
      pre = $urandom_range(5, 25);
      repeat (pre) cycle($urandom_range(0, 99) < 40);
      do_reset(1);
      lag = $urandom_range(0, 30);
      run_epochs(lag + 4, 40);
      check("gap_lock", int'(lock), 1);
      check("gap_phase", int'(code_phase), lag);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
